// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signal bundle for mem_arbiter
//   slave  : arbiter view (requests and mem_rdata in; grants, responses and mem_* out)
//   master : requester/memory view (the opposite directions)
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_mode;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_mode, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_read, mem_write, mem_mode, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_mode, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_read, mem_write, mem_mode, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-addressed memory between fetch and load/store, data first with bounded fetch starvation
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : mem_arbiter_if.slave (fetch port, data port, memory port)
module mem_arbiter #(
  parameter int MEM_BYTES  = 4096,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} own_t;
  own_t          r_owner;
  logic          r_err;
  logic          r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_if_gnt;
  logic          w_d_gnt;
  logic          w_gnt;
  logic          w_bad_mode;
  logic          w_misalign;
  logic          w_range;
  logic          w_err;
  logic          w_rd;
  logic          w_if_rsp;
  logic          w_d_rsp;
  logic [2:0]    w_size;
  logic [31:0]   w_addr;
  logic [32:0]   w_end;
  always_comb begin
    w_if_gnt   = rst & bus.if_req & (~bus.d_req | (r_cnt == CW'(STARVE_MAX)));
    w_d_gnt    = rst & bus.d_req & ~w_if_gnt;
    w_gnt      = w_if_gnt | w_d_gnt;
    w_addr     = w_if_gnt ? bus.if_addr : bus.d_addr;
    w_bad_mode = ~w_if_gnt & (bus.d_we ? bus.d_mode > 3'd2 : bus.d_mode > 3'd4);
    w_size     = (w_if_gnt | bus.d_mode == 3'd0) ? 3'd4 :
                 (bus.d_mode == 3'd1 | bus.d_mode == 3'd3) ? 3'd2 : 3'd1;
    // compressed instructions make halfword-aligned fetches legal
    w_misalign = (w_size == 3'd4) ? (w_if_gnt ? w_addr[0] : |w_addr[1:0]) :
                 (w_size == 3'd2) & w_addr[0];
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    w_end      = {1'b0, w_addr} + 33'(w_size) - 33'd1;
    w_range    = w_end >= 33'(MEM_BYTES);
    w_err      = w_bad_mode | w_misalign | w_range;
    w_rd       = w_gnt & ~w_err & (w_if_gnt | ~bus.d_we);
    w_if_rsp   = rst & (r_owner == OWN_IF);
    w_d_rsp    = rst & (r_owner == OWN_D);
  end
  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_read  = w_rd;
  assign bus.mem_write = w_d_gnt & ~w_err & bus.d_we;
  assign bus.mem_mode  = w_d_gnt ? bus.d_mode : 3'd0;
  assign bus.mem_addr  = w_gnt ? w_addr : 32'd0;
  assign bus.mem_wdata = w_d_gnt ? bus.d_wdata : 32'd0;
  assign bus.if_rvalid = w_if_rsp;
  assign bus.if_err    = w_if_rsp & r_err;
  assign bus.if_rdata  = (w_if_rsp & r_rd) ? bus.mem_rdata : 32'd0;
  assign bus.d_rvalid  = w_d_rsp;
  assign bus.d_err     = w_d_rsp & r_err;
  assign bus.d_rdata   = (w_d_rsp & r_rd) ? bus.mem_rdata : 32'd0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_owner <= w_if_gnt ? OWN_IF : w_d_gnt ? OWN_D : OWN_NONE;
      r_err   <= w_gnt & w_err;
      r_rd    <= w_rd;
      r_cnt   <= (~bus.if_req | w_if_gnt) ? '0 :
                 (w_d_gnt & (r_cnt != CW'(STARVE_MAX))) ? r_cnt + CW'(1) : r_cnt;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus response scoreboard for mem_arbiter
module tb_mem_arbiter;
  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        we;
    logic [2:0]  md;
    logic [31:0] da;
    logic [31:0] wd;
    logic        eig;
    logic        edg;
    logic        erd;
    logic        ewr;
    logic        eer;
  } vec_t;
  typedef struct {
    logic        own_if;
    logic        err;
    logic [31:0] data;
  } rsp_t;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  rsp_t q[$];
  vec_t tbl[$];
  logic pend_rd;
  logic [31:0] pend_addr;
  mem_arbiter_if bus ();
  mem_arbiter #(.MEM_BYTES(4096), .STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input vec_t v);
    rsp_t r;
    bus.if_req    = v.ir;
    bus.if_addr   = v.ia;
    bus.d_req     = v.dr;
    bus.d_we      = v.we;
    bus.d_mode    = v.md;
    bus.d_addr    = v.da;
    bus.d_wdata   = v.wd;
    bus.mem_rdata = pend_rd ? mem_f(pend_addr) : 32'hBAD0_BAD0;
    #1;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("if_rvalid", bus.if_rvalid, r.own_if);
      chk("d_rvalid", bus.d_rvalid, !r.own_if);
      chk(r.own_if ? "if_err" : "d_err", r.own_if ? bus.if_err : bus.d_err, r.err);
      chk(r.own_if ? "if_rdata" : "d_rdata", r.own_if ? bus.if_rdata : bus.d_rdata, r.data);
    end else begin
      chk("if_rvalid idle", bus.if_rvalid, 0);
      chk("d_rvalid idle", bus.d_rvalid, 0);
    end
    chk("if_gnt", bus.if_gnt, v.eig);
    chk("d_gnt", bus.d_gnt, v.edg);
    chk("mem_read", bus.mem_read, v.erd);
    chk("mem_write", bus.mem_write, v.ewr);
    if (v.erd || v.ewr) begin
      chk("mem_mode", bus.mem_mode, v.eig ? 3'd0 : v.md);
      chk("mem_addr", bus.mem_addr, v.eig ? v.ia : v.da);
      chk("mem_wdata", bus.mem_wdata, v.eig ? 32'd0 : v.wd);
    end else if (!v.eig && !v.edg) begin
      chk("mem_addr idle", bus.mem_addr, 0);
      chk("mem_wdata idle", bus.mem_wdata, 0);
    end
    if (v.eig || v.edg)
      q.push_back('{v.eig, v.eer, (v.erd && !v.eer) ? mem_f(v.eig ? v.ia : v.da) : 32'd0});
    pend_rd   = v.erd;
    pend_addr = v.eig ? v.ia : v.da;
    @(negedge clk);
  endtask
  vec_t idle;
  vec_t v;
  initial begin
    idle = '{1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl = '{
      '{1'b1, 32'h080, 1'b1, 1'b0, 3'd0, 32'h040, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 32'h100, 1'b0, 1'b0, 3'd0, 32'h000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 32'h000, 1'b1, 1'b1, 3'd1, 32'h202, 32'h1234,     1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
      '{1'b0, 32'h000, 1'b1, 1'b0, 3'd3, 32'h202, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 32'h000, 1'b1, 1'b0, 3'd0, 32'h002, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h000, 1'b1, 1'b1, 3'd3, 32'h010, 32'h55,       1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h000, 1'b1, 1'b0, 3'd0, 32'hFFE, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h000, 1'b1, 1'b0, 3'd0, 32'hFFC, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 32'h000, 1'b1, 1'b0, 3'd1, 32'hFFE, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 32'h000, 1'b1, 1'b0, 3'd4, 32'hFFF, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 32'h000, 1'b1, 1'b0, 3'd2, 32'h1000, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h000, 1'b1, 1'b0, 3'd5, 32'h020, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h000, 1'b1, 1'b1, 3'd4, 32'h020, 32'h77,       1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h000, 1'b1, 1'b1, 3'd0, 32'h300, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
      '{1'b0, 32'h000, 1'b1, 1'b1, 3'd2, 32'h301, 32'hAB,       1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
      '{1'b0, 32'h000, 1'b1, 1'b0, 3'd1, 32'h203, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b1, 32'h001, 1'b0, 1'b0, 3'd0, 32'h000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 32'h102, 1'b0, 1'b0, 3'd0, 32'h000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 32'hFFC, 1'b0, 1'b0, 3'd0, 32'h000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 32'hFFE, 1'b0, 1'b0, 3'd0, 32'h000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h000, 1'b0, 1'b0, 3'd0, 32'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 32'h104, 1'b0, 1'b0, 3'd0, 32'h000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0}
    };
    rst = 1'b0;
    pend_rd = 1'b0;
    pend_addr = 32'h0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_mode = 3'd0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.mem_rdata = 32'h0;
    @(negedge clk);
    v = '{1'b1, 32'h080, 1'b1, 1'b0, 3'd0, 32'h040, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(v);
    step(v);
    rst = 1'b1;
    foreach (tbl[i]) step(tbl[i]);
    step(idle);
    for (int k = 0; k < 12; k++) begin
      v = '{1'b1, 32'h080, 1'b1, 1'b0, 3'd0, 32'h040, 32'h0, (k % 5 == 4), (k % 5 != 4), 1'b1, 1'b0, 1'b0};
      step(v);
    end
    step(idle);
    v = '{1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 32'h044, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    step(v);
    rst = 1'b0;
    q.delete();
    pend_rd = 1'b0;
    step(idle);
    step(idle);
    rst = 1'b1;
    step(idle);
    v = '{1'b1, 32'h080, 1'b1, 1'b0, 3'd0, 32'h040, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    step(v);
    step(idle);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified byte-addressed memory between the instruction-fetch unit and the load/store unit of the RV32IC core.
- Data accesses have priority, with a bounded-starvation guarantee for fetch. Illegal modes, misaligned accesses and out-of-range accesses are rejected before they reach memory.
- One access is issued per cycle, and its response returns on the next cycle.

Parameters:
- MEM_BYTES, 4096, memory size in bytes; accesses touching byte >= MEM_BYTES are errors.
- STARVE_MAX, 4, maximum consecutive data grants allowed while a fetch is waiting.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset.
- if_req  in  1  fetch request; address must be held stable until if_gnt.
- if_addr  in  32  fetch byte address; always a word read (mode 000).
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  32  fetch data; 0 when if_err.
- if_err  out  1  fetch rejected; qualified by if_rvalid.
- d_req  in  1  data request; d_we/d_mode/d_addr/d_wdata must be held stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_mode  in  3  width/extension code:
  - 000 word
  - 001 unsigned halfword / store halfword
  - 010 unsigned byte / store byte
  - 011 signed halfword
  - 100 signed byte
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response valid (load data or store acknowledge).
- d_rdata  out  32  load data; 0 for stores and errors.
- d_err  out  1  data request rejected; qualified by d_rvalid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_mode  out  3  mode forwarded to memory.
- mem_addr  out  32  address forwarded to memory.
- mem_wdata  out  32  store data forwarded to memory.
- mem_rdata  in  32  memory read data, valid the cycle after mem_read.

Behaviour:
- Reset (rst=0 at rising edge):
  - if_rvalid, d_rvalid, if_err, d_err = 0.
  - if_rdata, d_rdata = 0.
  - Starvation counter = 0; pending-owner tag = NONE.
  - While rst=0: if_gnt, d_gnt, mem_read, mem_write = 0.
- Grant (combinational, in the request cycle):
  - Only one requester: it is granted.
  - Both requesting: d wins unless the starvation counter == STARVE_MAX, in which case if wins.
  - Exactly one gnt per cycle at most.
- Legality check on the granted request:
  - Illegal mode: d_mode in 101..111 for loads; d_mode > 010 for stores.
  - Misaligned: word with addr[1:0]!=0; halfword with addr[0]!=0; fetch with if_addr[0]!=0 (halfword-aligned fetch is legal for RVC).
  - Range: addr + size - 1 >= MEM_BYTES, where size is 4/2/1 and fetch size is 4.
- Issue:
  - Legal grant drives mem_read (load/fetch) or mem_write (store) with mem_mode/mem_addr/mem_wdata in the same cycle.
  - Fetch drives mem_mode=000 and mem_wdata=0.
  - Illegal grant drives no strobe.
  - No grant: strobes 0, other mem_* outputs 0.
- Response (registered, latency exactly 1 cycle after gnt):
  - Pending-owner tag (NONE/IF/D) and error flag are registered at grant.
  - Next cycle, the owner's rvalid=1 for one cycle.
  - rdata = mem_rdata for legal reads; 0 for stores and errors.
  - err = registered error flag.
- Pipelining: a new grant may occur in the same cycle as the previous response; full throughput is 1 access/cycle.
- Starvation counter (saturating at STARVE_MAX):
  - Increments on each d grant while if_req=1 and if not granted.
  - Clears on any if grant or any cycle with if_req=0.
  - Rejected data accesses count as grants.
- Reset mid-operation: a pending response is discarded (no rvalid after reset); the counter clears.
- Requesters may drop req only after gnt; dropping before gnt is a protocol violation (not checked).

Test Plan:
- Reset: rst=0 for 2 cycles with if_req=d_req=1 → all gnt/strobes/rvalid 0; after rst=1 the first grant goes to d.
- Single fetch: if_req, if_addr=0x100, mem_rdata=0xDEADBEEF next cycle → if_gnt cycle N, mem_read=1, mem_addr=0x100, mem_mode=000; if_rvalid=1, if_rdata=0xDEADBEEF, if_err=0 at N+1.
- Store/load: d store mode 001, addr 0x202, wdata 0x1234 → mem_write=1, d_rvalid at N+1 with d_rdata=0. Then load mode 011, addr 0x202 → mem_read=1, mem_mode=011.
- Errors, each → d_rvalid=1, d_err=1, d_rdata=0, no strobe:
  - d load word addr 0x0002.
  - Store mode 011.
  - Word addr 0x0FFE with MEM_BYTES=4096.
- Fetch error: if_addr=0x0001 → if_err=1 at N+1, no strobe.
- Starvation, STARVE_MAX=4: if_req and d_req held high continuously → d granted 4 consecutive cycles, then if granted in cycle 5, then d again.
- Reset mid-access: d load granted cycle N, rst=0 in cycle N+1 → d_rvalid stays 0.
